// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: MUL/DIV FSM states, the zero
// register id, and the control-word encodings driven by the stall unit.
package cpu_pkg;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_MD_BUSY = 1'b1
   } md_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic id_ex_write;
      logic id_ex_bubble;
      logic if_id_flush;
      logic ex_mem_bubble;
   } ctl_t;

   // Control words, field order as in ctl_t
   localparam ctl_t CTL_RUN      = 6'b111000;
   localparam ctl_t CTL_RESET    = 6'b000100;
   localparam ctl_t CTL_MD_STALL = 6'b000001;
   localparam ctl_t CTL_FLUSH    = 6'b111110;
   localparam ctl_t CTL_LOAD_USE = 6'b001100;

   function automatic logic load_use_hit(
      input logic       memread,
      input logic [4:0] ex_rt,
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic       uses_rt
   );
      return memread && (ex_rt != REG_ZERO) &&
             ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: q increments on inc and sticks at all-ones.
// Ports: clk, rst_n (async, active low), inc, q[CNT_W-1:0].
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-side hazard control: load-use stall, taken-branch flush, MUL/DIV
// EX occupancy. Drives PC/IF-ID/ID-EX/EX-MEM enables and bubbles
// combinationally, plus saturating stall/flush cycle counters.
module hazard_stall_unit
   import cpu_pkg::*;
#(
   parameter int MULDIV_CYCLES = 4,
   parameter int CNT_W         = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_ex_memread,
   input  logic [4:0]       id_ex_rt,
   input  logic [4:0]       if_id_rs,
   input  logic [4:0]       if_id_rt,
   input  logic             if_id_uses_rt,
   input  logic             branch_taken,
   input  logic             muldiv_start,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_write,
   output logic             id_ex_bubble,
   output logic             if_id_flush,
   output logic             ex_mem_bubble,
   output logic             muldiv_busy,
   output logic             muldiv_done,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_cycles
);

   localparam int MDW = $clog2(MULDIV_CYCLES);

   md_state_e        state;
   logic [MDW-1:0]   md_cnt;
   ctl_t             ctl;
   logic             done_c;
   logic             hit;

   assign hit = load_use_hit(id_ex_memread, id_ex_rt,
                             if_id_rs, if_id_rt, if_id_uses_rt);

   // Outputs are forced to the reset word while rst_n is low so the
   // pipeline freezes immediately rather than at the next edge.
   always_comb begin
      ctl    = CTL_RUN;
      done_c = 1'b0;
      if (!rst_n) begin
         ctl = CTL_RESET;
      end else if (state == ST_MD_BUSY) begin
         if (md_cnt != '0) begin
            ctl = CTL_MD_STALL;
         end else begin
            done_c = 1'b1;
         end
      end else if (muldiv_start) begin
         ctl = CTL_MD_STALL;
      end else if (branch_taken) begin
         // flush wins: the instruction that would stall is discarded
         ctl = CTL_FLUSH;
      end else if (hit) begin
         ctl = CTL_LOAD_USE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_RUN;
         md_cnt <= '0;
      end else begin
         unique case (state)
            ST_RUN: begin
               if (muldiv_start) begin
                  md_cnt <= MDW'(MULDIV_CYCLES - 2);
                  state  <= ST_MD_BUSY;
               end
            end
            ST_MD_BUSY: begin
               if (md_cnt != '0) begin
                  md_cnt <= md_cnt - MDW'(1);
               end else begin
                  state <= ST_RUN;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   assign pc_write      = ctl.pc_write;
   assign if_id_write   = ctl.if_id_write;
   assign id_ex_write   = ctl.id_ex_write;
   assign id_ex_bubble  = ctl.id_ex_bubble;
   assign if_id_flush   = ctl.if_id_flush;
   assign ex_mem_bubble = ctl.ex_mem_bubble;
   assign muldiv_busy   = rst_n && (state == ST_MD_BUSY);
   assign muldiv_done   = done_c;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (~ctl.pc_write),
      .q     (stall_cycles)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (ctl.if_id_flush),
      .q     (flush_cycles)
   );

endmodule
